// File: rtl/relm_ps2_device.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : relm_ps2_device                                               |
// | Purpose  : Device-side PS/2 endpoint. Generates the PS/2 clock, sends    |
// |            bytes pushed by the CPU and receives host commands with ACK.  |
// |            Optional macro PS2_DEVICE_BAT_EN: send 0xAA BAT_DELAY cycles  |
// |            after reset release.                                          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module relm_ps2_device #(
  parameter int WD        = 32,
  parameter int HALF      = 2000,
  parameter int BAT_DELAY = 25000000
) (
  input  logic        clk,
  input  logic        rst_n_in,
  input  logic [WD:0] tx_d_in,
  output logic        tx_retry_out,
  input  logic [WD:0] rx_d_in,
  output logic [WD:0] rx_q_out,
  inout  wire  [1:0]  ps2_inout
);

  localparam int            CW          = $clog2(2 * HALF);
  localparam logic [CW-1:0] C_CELL_LAST = CW'(2 * HALF - 1);
  localparam logic [CW-1:0] C_HALF      = CW'(HALF);
  localparam logic [CW-1:0] C_TX_CHK    = CW'(HALF / 2);
  localparam logic [CW-1:0] C_RX_SMP    = CW'(HALF + HALF / 2);
  localparam logic [3:0]    C_BIT_LAST  = 4'd10;
  localparam logic [3:0]    C_BIT_STOP  = 4'd9;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TX   = 2'd1,
    S_RX   = 2'd2,
    S_ACK  = 2'd3
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cyc, w_cyc_nxt;
  logic [3:0]    r_bit, w_bit_nxt, w_bit_inc;
  logic          w_cell_end;

  logic [7:0]    r_clk_sh, r_dat_sh, w_clk_sh_nxt, w_dat_sh_nxt;
  logic          r_clk_f, r_dat_f;

  logic          r_pending;
  logic [7:0]    r_tx_byte;
  logic [10:0]   w_tx_frame;
  logic          w_tx_done, w_bat_load;

  logic [9:0]    r_rx_sh;
  logic          w_rx_sample, w_rx_write;
  logic          r_rx_valid, r_overrun, r_par_err;
  logic [7:0]    r_rx_byte;

  logic          r_rts_arm, w_arm_clr;
  logic          w_clk_low, w_data_low;
  logic          w_unused;

  // Only the strobes and the low byte of the CPU words carry meaning.
  assign w_unused = ^{tx_d_in[WD-1:8], rx_d_in[WD-1:0]};

  // Open-drain drivers: pull low or float.
  assign ps2_inout[0] = w_clk_low  ? 1'b0 : 1'bz;
  assign ps2_inout[1] = w_data_low ? 1'b0 : 1'bz;

  assign w_clk_sh_nxt = {r_clk_sh[6:0], ps2_inout[0]};
  assign w_dat_sh_nxt = {r_dat_sh[6:0], ps2_inout[1]};

  // Line filters: the filtered level moves only when 8 samples agree.
  always_ff @(posedge clk or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_clk_sh <= '1;
      r_dat_sh <= '1;
      r_clk_f  <= 1'b1;
      r_dat_f  <= 1'b1;
    end else begin
      r_clk_sh <= w_clk_sh_nxt;
      r_dat_sh <= w_dat_sh_nxt;
      if (&w_clk_sh_nxt)       r_clk_f <= 1'b1;
      else if (~|w_clk_sh_nxt) r_clk_f <= 1'b0;
      if (&w_dat_sh_nxt)       r_dat_f <= 1'b1;
      else if (~|w_dat_sh_nxt) r_dat_f <= 1'b0;
    end
  end

  // Frame as seen on the data line: start, LSB-first data, odd parity, stop.
  assign w_tx_frame = {1'b1, ~^r_tx_byte, r_tx_byte, 1'b0};
  assign w_cell_end = (r_cyc == C_CELL_LAST);
  assign w_bit_inc  = (r_bit == C_BIT_LAST) ? C_BIT_LAST : r_bit + 4'd1;

  // State, cell-cycle and bit-index registers.
  always_ff @(posedge clk or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state <= S_IDLE;
      r_cyc   <= '0;
      r_bit   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cyc   <= w_cyc_nxt;
      r_bit   <= w_bit_nxt;
    end
  end

  // Next-state, counter reloads, line drive and datapath strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_cyc_nxt   = r_cyc;
    w_bit_nxt   = r_bit;
    w_clk_low   = 1'b0;
    w_data_low  = 1'b0;
    w_tx_done   = 1'b0;
    w_rx_sample = 1'b0;
    w_rx_write  = 1'b0;
    w_arm_clr   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cyc_nxt = '0;
        w_bit_nxt = '0;
        // A host request-to-send wins over a pending transmit.
        if (r_clk_f && !r_dat_f && r_rts_arm)     w_state_nxt = S_RX;
        else if (r_pending && r_clk_f && r_dat_f) w_state_nxt = S_TX;
      end
      S_TX: begin
        w_data_low = ~w_tx_frame[r_bit];
        w_clk_low  = (r_cyc >= C_HALF);
        w_cyc_nxt  = r_cyc + CW'(1);
        if (r_cyc == C_TX_CHK && !r_clk_f && r_bit != C_BIT_LAST) begin
          // Host inhibit: drop the frame, the byte stays pending.
          w_state_nxt = S_IDLE;
        end else if (w_cell_end) begin
          w_cyc_nxt = '0;
          w_bit_nxt = w_bit_inc;
          if (r_bit == C_BIT_LAST) begin
            w_tx_done   = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_RX: begin
        w_clk_low   = (r_cyc < C_HALF);
        w_cyc_nxt   = r_cyc + CW'(1);
        w_rx_sample = (r_cyc == C_RX_SMP);
        if (w_cell_end) begin
          w_cyc_nxt = '0;
          w_bit_nxt = w_bit_inc;
          if (r_bit == C_BIT_STOP) begin
            if (r_rx_sh[9]) begin
              w_state_nxt = S_ACK;
            end else begin
              w_state_nxt = S_IDLE;
              w_arm_clr   = 1'b1;
            end
          end
        end
      end
      S_ACK: begin
        w_data_low = 1'b1;
        w_clk_low  = (r_cyc < C_HALF);
        w_cyc_nxt  = r_cyc + CW'(1);
        if (w_cell_end) begin
          w_cyc_nxt   = '0;
          w_bit_nxt   = w_bit_inc;
          w_rx_write  = 1'b1;
          w_arm_clr   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Our own ACK leaves data low for one filter delay after release; RTS
  // detection stays disarmed until the filtered data line has been seen high.
  always_ff @(posedge clk or negedge rst_n_in) begin
    if (!rst_n_in)      r_rts_arm <= 1'b1;
    else if (w_arm_clr) r_rts_arm <= 1'b0;
    else if (r_dat_f)   r_rts_arm <= 1'b1;
  end

`ifdef PS2_DEVICE_BAT_EN
  localparam int BW = $clog2(BAT_DELAY + 1);
  logic [BW-1:0] r_bat_cnt;
  logic          r_bat_done;

  assign w_bat_load = !r_bat_done && (r_bat_cnt == BW'(BAT_DELAY)) && !r_pending;

  // One-shot power-on delay before the BAT byte is queued.
  always_ff @(posedge clk or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_bat_cnt  <= '0;
      r_bat_done <= 1'b0;
    end else if (!r_bat_done) begin
      if (r_bat_cnt != BW'(BAT_DELAY)) r_bat_cnt  <= r_bat_cnt + BW'(1);
      else if (!r_pending)             r_bat_done <= 1'b1;
    end
  end
`else
  // No BAT: BAT_DELAY is never negative, so this is constant 0.
  assign w_bat_load = (BAT_DELAY < 0);
`endif

  // Transmit holding register.
  always_ff @(posedge clk or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_pending <= 1'b0;
      r_tx_byte <= '0;
    end else if (w_tx_done) begin
      r_pending <= 1'b0;
    end else if (w_bat_load) begin
      r_pending <= 1'b1;
      r_tx_byte <= 8'hAA;
    end else if (tx_d_in[WD] && !r_pending) begin
      r_pending <= 1'b1;
      r_tx_byte <= tx_d_in[7:0];
    end
  end

  assign tx_retry_out = r_pending;

  // Receive shifter: after 10 samples, [7:0] data, [8] parity, [9] stop.
  always_ff @(posedge clk or negedge rst_n_in) begin
    if (!rst_n_in)        r_rx_sh <= '0;
    else if (w_rx_sample) r_rx_sh <= {r_dat_f, r_rx_sh[9:1]};
  end

  // Receive buffer; a write in the same cycle as a pop keeps the new byte.
  always_ff @(posedge clk or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_rx_valid <= 1'b0;
      r_overrun  <= 1'b0;
      r_par_err  <= 1'b0;
      r_rx_byte  <= '0;
    end else if (w_rx_write) begin
      r_rx_byte  <= r_rx_sh[7:0];
      r_par_err  <= ~^r_rx_sh[8:0];
      r_overrun  <= r_rx_valid;
      r_rx_valid <= 1'b1;
    end else if (rx_d_in[WD]) begin
      r_rx_valid <= 1'b0;
      r_overrun  <= 1'b0;
      r_par_err  <= 1'b0;
    end
  end

  assign rx_q_out = {~r_rx_valid, {(WD-10){1'b0}}, r_overrun, r_par_err, r_rx_byte};

endmodule
`default_nettype wire
